// File: rtl/wbu_commit.sv
// Write-back/commit stage: in-order commit queue between LSU and the register/CSR files,
// with exception prioritisation, trap/xret flush, a retire counter and a no-progress watchdog.
module wbu_commit #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 2,
    parameter int EXCP_W    = 16,
    parameter int WDT_LIMIT = 8192
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [XLEN-1:0]          in_pc_i,
    input  logic                     in_gr_we_i,
    input  logic [4:0]               in_rd_i,
    input  logic [XLEN-1:0]          in_result_i,
    input  logic                     in_csr_we_i,
    input  logic [11:0]              in_csr_addr_i,
    input  logic [XLEN-1:0]          in_csr_wdata_i,
    input  logic                     in_xret_i,
    input  logic [EXCP_W-1:0]        in_excp_i,
    input  logic                     stall_i,
    output logic                     rf_we_o,
    output logic [4:0]               rf_rd_o,
    output logic [XLEN-1:0]          rf_wdata_o,
    output logic                     csr_we_o,
    output logic [11:0]              csr_addr_o,
    output logic [XLEN-1:0]          csr_wdata_o,
    output logic                     excp_flush_o,
    output logic                     mret_flush_o,
    output logic [XLEN-1:0]          csr_mcause_o,
    output logic [XLEN-1:0]          csr_mepc_o,
    output logic                     ebreak_o,
    output logic                     fwd_gpr_valid_o,
    output logic                     fwd_csr_valid_o,
    output logic                     retire_o,
    output logic [63:0]              retire_cnt_o,
    output logic                     wdt_timeout_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW = $clog2(WDT_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [WW-1:0] WDT_MAX  = WW'(WDT_LIMIT);

    logic [XLEN-1:0]   r_pc        [DEPTH];
    logic              r_gr_we     [DEPTH];
    logic [4:0]        r_rd        [DEPTH];
    logic [XLEN-1:0]   r_result    [DEPTH];
    logic              r_csr_we    [DEPTH];
    logic [11:0]       r_csr_addr  [DEPTH];
    logic [XLEN-1:0]   r_csr_wdata [DEPTH];
    logic              r_xret      [DEPTH];
    logic [EXCP_W-1:0] r_excp      [DEPTH];

    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_cnt;
    logic [63:0]       r_retire_cnt;
    logic [WW-1:0]     r_wdt_cnt;
    logic              r_wdt_to;

    logic              w_head_valid;
    logic              w_retire;
    logic              w_trap;
    logic              w_flush;
    logic              w_push;
    logic [XLEN-1:0]   w_cause;
    logic [WW-1:0]     w_wdt_next;
    logic [EXCP_W-1:0] w_h_excp;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Nothing retires during the reset cycle, so no enable or flush can leak out of it.
    assign w_head_valid = (r_cnt != '0);
    assign w_retire     = w_head_valid && !stall_i && !reset;
    assign w_h_excp     = r_excp[r_rd_ptr];
    assign w_trap       = w_retire && (w_h_excp != '0);
    assign w_flush      = w_retire && ((w_h_excp != '0) || r_xret[r_rd_ptr]);
    assign in_ready_o   = (r_cnt < DEPTH_C);
    assign w_push       = in_valid_i && in_ready_o && !w_flush;

    // Lowest set exception bit has the highest priority.
    always_comb begin
        w_cause = '0;
        for (int i = EXCP_W - 1; i >= 0; i--) begin
            if (w_h_excp[i]) begin
                w_cause = XLEN'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_pc[r_wr_ptr]        <= in_pc_i;
            r_gr_we[r_wr_ptr]     <= in_gr_we_i;
            r_rd[r_wr_ptr]        <= in_rd_i;
            r_result[r_wr_ptr]    <= in_result_i;
            r_csr_we[r_wr_ptr]    <= in_csr_we_i;
            r_csr_addr[r_wr_ptr]  <= in_csr_addr_i;
            r_csr_wdata[r_wr_ptr] <= in_csr_wdata_i;
            r_xret[r_wr_ptr]      <= in_xret_i;
            r_excp[r_wr_ptr]      <= in_excp_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_retire) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_retire})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_comb begin
        if (w_retire) begin
            w_wdt_next = '0;
        end else if (r_wdt_cnt != WDT_MAX) begin
            w_wdt_next = r_wdt_cnt + 1'b1;
        end else begin
            w_wdt_next = r_wdt_cnt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_retire_cnt <= '0;
            r_wdt_cnt    <= '0;
            r_wdt_to     <= 1'b0;
        end else begin
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + 64'd1;
            end
            r_wdt_cnt <= w_wdt_next;
            if (w_wdt_next == WDT_MAX) begin
                r_wdt_to <= 1'b1;
            end
        end
    end

    // Data and addresses always show the head; only the enables are qualified.
    assign rf_rd_o         = r_rd[r_rd_ptr];
    assign rf_wdata_o      = r_result[r_rd_ptr];
    assign csr_addr_o      = r_csr_addr[r_rd_ptr];
    assign csr_wdata_o     = r_csr_wdata[r_rd_ptr];
    assign csr_mepc_o      = r_pc[r_rd_ptr];
    assign rf_we_o         = w_retire && !w_trap && r_gr_we[r_rd_ptr] && (r_rd[r_rd_ptr] != 5'd0);
    assign csr_we_o        = w_retire && !w_trap && r_csr_we[r_rd_ptr];
    assign excp_flush_o    = w_trap;
    assign mret_flush_o    = w_retire && !w_trap && r_xret[r_rd_ptr];
    assign csr_mcause_o    = w_trap ? w_cause : '0;
    assign ebreak_o        = w_trap && (w_cause == XLEN'(3));
    assign fwd_gpr_valid_o = rf_we_o;
    assign fwd_csr_valid_o = csr_we_o;
    assign retire_o        = w_retire;
    assign retire_cnt_o    = r_retire_cnt;
    assign wdt_timeout_o   = r_wdt_to;
    assign occupancy_o     = r_cnt;

endmodule

// File: doc/wbu_commit.md
Name: wbu_commit

Overview:
Parametrised write-back/commit stage that succeeds the single-entry WBU. It sits between LSU and the register file / CSR file. A DEPTH-entry in-order commit queue decouples the LSU from retirement. The stage retires one instruction per cycle unless stalled, prioritises exceptions through a generic EXCP_W-bit vector, flushes younger queued work on trap or xret, and provides a retire counter and a configurable no-progress watchdog.

Parameters:
XLEN, 32, data/PC width
DEPTH, 2, commit queue entries (power of two, >=1)
EXCP_W, 16, exception vector width; bit i set means mcause code i
WDT_LIMIT, 8192, consecutive non-retiring cycles before timeout

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid_i  in  1  LSU entry valid
in_ready_o  out  1  queue can accept
in_pc_i  in  XLEN  instruction PC
in_gr_we_i  in  1  GPR write request
in_rd_i  in  5  GPR index
in_result_i  in  XLEN  GPR write data
in_csr_we_i  in  1  CSR write request
in_csr_addr_i  in  12  CSR address
in_csr_wdata_i  in  XLEN  CSR write data
in_xret_i  in  1  mret
in_excp_i  in  EXCP_W  exception vector
stall_i  in  1  hold retirement (debug/halt)
rf_we_o, rf_rd_o(5), rf_wdata_o(XLEN)  out  GPR write port
csr_we_o, csr_addr_o(12), csr_wdata_o(XLEN)  out  CSR write port
excp_flush_o  out  1  trap taken this cycle
mret_flush_o  out  1  xret retired this cycle
csr_mcause_o  out  XLEN  trap cause
csr_mepc_o  out  XLEN  trapping PC
ebreak_o  out  1  breakpoint retired (simulation end hook)
fwd_gpr_valid_o, fwd_csr_valid_o  out  1  forwarding qualifiers for head entry
retire_o  out  1  an instruction retired
retire_cnt_o  out  64  total retired instructions
wdt_timeout_o  out  1  watchdog expired (sticky)
occupancy_o  out  $clog2(DEPTH)+1  queued entries

Behaviour:
- Reset: queue empty, counters 0, wdt_timeout_o 0. All write, flush, and pulse outputs are 0 while the queue is empty.
- Accept: push when in_valid_i && in_ready_o. in_ready_o = (occupancy < DEPTH), derived from registered state only. An entry accepted at edge t is at the head after t at the earliest, so it can retire in cycle t+1.
- Head retires in a cycle when queue non-empty && !stall_i; pop at the following edge.
- Head with any excp bit set (trap):
  - rf_we_o = csr_we_o = 0.
  - excp_flush_o = 1.
  - csr_mcause_o = index of the lowest set bit, zero-extended.
  - csr_mepc_o = head PC.
  - ebreak_o = 1 if the lowest set bit is 3.
- Head with xret and no exception: mret_flush_o = 1. GPR/CSR writes follow that entry's enables.
- Normal head: rf_we_o = gr_we && rd!=0; csr_we_o = csr_we.
- Write data and addresses always reflect the head entry. Only the enables are qualified.
- Trap or xret retiring: all younger entries are discarded and any same-cycle push is dropped. The queue is empty after the edge.
- csr_mcause_o = 0 and csr_mepc_o = head PC when no trap is taken.
- retire_o = 1 on every retirement, traps included. retire_cnt_o increments by 1 at that edge and wraps modulo 2^64.
- Watchdog: count resets to 0 on any retirement, otherwise increments. When the count reaches WDT_LIMIT, wdt_timeout_o is set, stays 1 until reset, and the count saturates.
- fwd_gpr_valid_o = rf_we_o. fwd_csr_valid_o = csr_we_o.
- stall_i holds the head. Pushes continue until the queue is full.
- Reset asserted mid-operation empties the queue in one cycle. No write enable or flush is asserted during the reset cycle.

Test Plan:
- Single add, pc=0x80000000, rd=5, result=0x1234 -> rf_we_o=1 with rd 5 and data 0x1234 one cycle after acceptance; retire_cnt_o=1.
- rd=0 with gr_we=1 -> rf_we_o=0, retire_o=1, fwd_gpr_valid_o=0.
- DEPTH=2, stall_i=1, push 3 entries -> in_ready_o drops after the 2nd entry, occupancy_o=2; release the stall -> in-order writes on two consecutive cycles.
- Head excp=0x0108 (bits 3 and 8), pc=0x80000010, one younger entry queued -> excp_flush_o=1, mcause=3, mepc=0x80000010, ebreak_o=1, no writes; younger entry never retires; occupancy_o=0 afterwards.
- mret followed by a queued csrw -> mret_flush_o=1 for one cycle; csrw discarded; csr_we_o stays 0.
- WDT_LIMIT=16, no input for 16 cycles after reset -> wdt_timeout_o rises on cycle 16 and stays high after later retirements; reset clears it.
